if_fetch_queue: RTL and testbench

Parametrised next-generation fetch stage.
- Holds the PC and a synchronous instruction memory.
- Decouples fetch from decode through a DEPTH-entry prefetch queue with a valid/ready handshake.
- Adds branch redirect with queue flush, debug-unit instruction loading, and step gating.
- Sits between the debug unit/loader and the ID stage; replaces the single-register fetch path.

---
 rtl/if_fetch_queue_pkg.sv | 15 +
 rtl/if_fetch_queue_if.sv | 44 ++++
 rtl/if_fetch_queue_fetch_queue.sv | 64 ++++++
 rtl/if_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and the prefetch-queue entry type for the if_fetch_queue fetch stage.
// The halt feature is enabled with IF_HALT_DETECT_EN; the package is identical in both builds.
package if_pkg;

    localparam int          IF_NB       = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_INCR     = 32'h0000_0004;

    typedef struct packed {
        logic [IF_NB-1:0] pc;
        logic [IF_NB-1:0] instr;
    } q_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Handshake/bus bundle between the fetch stage and its debug unit and ID stage.
// IF_HALT_DETECT_EN adds the o_halt signal.
interface if_fetch_queue_if #(
    parameter int NB    = 32,
    parameter int TAM_I = 256,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(TAM_I);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_step;
    logic          i_branch;
    logic [NB-1:0] i_branch_addr;
    logic          i_imem_we;
    logic [AW-1:0] i_imem_addr;
    logic [NB-1:0] i_imem_data;
    logic          i_ready;
    logic          o_valid;
    logic [NB-1:0] o_IF_pc;
    logic [NB-1:0] o_IF_pc4;
    logic [NB-1:0] o_IF_pc8;
    logic [NB-1:0] o_instruction;
    logic [CW-1:0] o_count;
`ifdef IF_HALT_DETECT_EN
    logic          o_halt;
`endif

    modport master (
        output i_step, i_branch, i_branch_addr, i_imem_we, i_imem_addr, i_imem_data, i_ready,
        input  o_valid, o_IF_pc, o_IF_pc4, o_IF_pc8, o_instruction, o_count
`ifdef IF_HALT_DETECT_EN
        , input o_halt
`endif
    );

    modport slave (
        input  i_step, i_branch, i_branch_addr, i_imem_we, i_imem_addr, i_imem_data, i_ready,
        output o_valid, o_IF_pc, o_IF_pc4, o_IF_pc8, o_instruction, o_count
`ifdef IF_HALT_DETECT_EN
        , output o_halt
`endif
    );

endinterface

// File: rtl/if_fetch_queue_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
// Push into a full queue and pop from an empty one are ignored.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  q_entry_t                   push_data,
    output q_entry_t                   head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    q_entry_t      store_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Guard push/pop against full/empty
    always_comb begin
        do_push_s = push && (count_r != CW'(DEPTH));
        do_pop_s  = pop  && (count_r != {CW{1'b0}});
    end

    // Entry storage; no reset needed, occupancy tracks validity
    always_ff @(posedge clk) begin
        if (do_push_s && !reset && !flush) begin
            store_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = store_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC, synchronous instruction memory and a prefetch queue towards ID.
// Define IF_HALT_DETECT_EN to stop fetching after HALT_OPCODE and expose o_halt.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int            NB       = 32,
    parameter int            TAM_I    = 256,
    parameter int            DEPTH    = 4,
    parameter logic [NB-1:0] PC_RESET = {NB{1'b0}}
) (
    input  logic          i_clk,
    input  logic          i_reset,
    if_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(TAM_I);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NB-1:0] mem_r [TAM_I];
    logic [NB-1:0] fetch_pc_r;
    logic [NB-1:0] issued_pc_r;
    logic [NB-1:0] rdata_r;
    logic          inflight_r;
    logic          halt_r;

    logic          en_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          halt_stop_s;
    logic [CW:0]   occ_s;
    logic [AW-1:0] rd_idx_s;
    logic [CW-1:0] count_s;
    q_entry_t      push_entry_s;
    q_entry_t      head_s;
    logic          valid_s;
    logic [NB-1:0] head_pc_s;
    logic [NB-1:0] head_instr_s;

    assign en_s     = bus.i_step && !i_reset;
    assign rd_idx_s = fetch_pc_r[AW+1:2];
    assign occ_s    = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};

`ifdef IF_HALT_DETECT_EN
    // A halt word sitting in the read register must block the issue running alongside its return
    assign halt_stop_s = halt_r || (inflight_r && (rdata_r == NB'(HALT_OPCODE)));
`else
    assign halt_stop_s = 1'b0;
`endif

    // Issue / return / pop / flush decisions for this cycle
    always_comb begin
        issue_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        flush_s = 1'b0;
        if (en_s) begin
            flush_s = bus.i_branch;
            push_s  = inflight_r && !bus.i_branch;
            pop_s   = valid_s && bus.i_ready && !bus.i_branch;
            issue_s = !bus.i_branch && !bus.i_imem_we && !halt_stop_s
                      && (occ_s < (CW+1)'(DEPTH));
        end else begin
            issue_s = 1'b0;
        end
    end

    // Instruction memory: debug write port and registered read port (read-before-write)
    always_ff @(posedge i_clk) begin
        if (en_s) begin
            if (bus.i_imem_we) begin
                mem_r[bus.i_imem_addr] <= bus.i_imem_data;
            end
            if (issue_s) begin
                rdata_r <= mem_r[rd_idx_s];
            end
        end
    end

    // PC, in-flight tracking and halt state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc_r  <= PC_RESET;
            issued_pc_r <= {NB{1'b0}};
            inflight_r  <= 1'b0;
            halt_r      <= 1'b0;
        end else if (bus.i_step) begin
            inflight_r <= issue_s;
            if (flush_s) begin
                fetch_pc_r <= bus.i_branch_addr;
            end else if (issue_s) begin
                fetch_pc_r  <= fetch_pc_r + NB'(PC_INCR);
                issued_pc_r <= fetch_pc_r;
            end
            if (flush_s) begin
                halt_r <= 1'b0;
            end else if (push_s && (rdata_r == NB'(HALT_OPCODE))) begin
                halt_r <= 1'b1;
            end
        end
    end

    assign push_entry_s.pc    = issued_pc_r;
    assign push_entry_s.instr = rdata_r;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (i_clk),
        .reset     (i_reset),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .push_data (push_entry_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Head presentation; an empty queue shows pc 0 and a NOP
    always_comb begin
        if (count_s != {CW{1'b0}}) begin
            valid_s      = 1'b1;
            head_pc_s    = head_s.pc;
            head_instr_s = head_s.instr;
        end else begin
            valid_s      = 1'b0;
            head_pc_s    = {NB{1'b0}};
            head_instr_s = NB'(NOP_INSTR);
        end
    end

    assign bus.o_valid       = valid_s;
    assign bus.o_IF_pc       = head_pc_s;
    assign bus.o_IF_pc4      = head_pc_s + NB'(PC_INCR);
    assign bus.o_IF_pc8      = head_pc_s + NB'(PC_INCR << 1);
    assign bus.o_instruction = head_instr_s;
    assign bus.o_count       = count_s;
`ifdef IF_HALT_DETECT_EN
    assign bus.o_halt        = halt_r;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: stimulus queues expected {pc, instr}, a negedge monitor checks pops.
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam int NB    = 32;
    localparam int TAM_I = 256;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.NB(NB), .TAM_I(TAM_I), .DEPTH(DEPTH)) bus ();

    if_fetch_queue #(
        .NB       (NB),
        .TAM_I    (TAM_I),
        .DEPTH    (DEPTH),
        .PC_RESET (32'h0000_0000)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    logic [31:0] model_mem [256];
    q_entry_t    sb [$];
    q_entry_t    mon_e;
    int          errors = 0;
    int          checks = 0;
    int          n_pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the next expected entry
    always @(negedge clk) begin
        if (!rst && bus.i_step && bus.o_valid && bus.i_ready && !bus.i_branch) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected no delivery", bus.o_IF_pc);
            end else begin
                mon_e = sb.pop_front();
                check("pop_pc",    bus.o_IF_pc,       mon_e.pc);
                check("pop_instr", bus.o_instruction, mon_e.instr);
                check("pop_pc4",   bus.o_IF_pc4,      mon_e.pc + 32'd4);
                check("pop_pc8",   bus.o_IF_pc8,      mon_e.pc + 32'd8);
            end
            n_pops++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_step = 1'b1;
        bus.i_branch = 1'b0;
        bus.i_imem_we = 1'b0;
        bus.i_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        n_pops = 0;
    endtask

    task automatic write_mem(input int idx, input logic [31:0] data);
        bus.i_imem_we   = 1'b1;
        bus.i_imem_addr = 8'(idx);
        bus.i_imem_data = data;
        model_mem[idx]  = data;
        tick();
        bus.i_imem_we   = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        q_entry_t    e;
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p       = start + 32'(4 * i);
            e.pc    = p;
            e.instr = model_mem[p[9:2]];
            sb.push_back(e);
        end
    endtask

    task automatic wait_pops(input int target, input string name);
        int cyc;
        cyc = 0;
        while (n_pops < target && cyc < 300) begin
            tick();
            cyc++;
        end
        if (n_pops < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pops expected %0d", name, n_pops, target);
        end
    endtask

    initial begin
        int maxc;
        int p0;
        int cyc;

        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0000_0000;
        bus.i_step        = 1'b1;
        bus.i_branch      = 1'b0;
        bus.i_branch_addr = 32'h0000_0000;
        bus.i_imem_we     = 1'b0;
        bus.i_imem_addr   = 8'h00;
        bus.i_imem_data   = 32'h0000_0000;
        bus.i_ready       = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_pc",    bus.o_IF_pc,       32'd0);
        check("rst_instr", bus.o_instruction, 32'd0);
        rst = 1'b0;

        // Preload (issue is held off while writing), then stream with i_ready=1
        for (int i = 0; i < 32; i++) begin
            write_mem(i, (i < 4) ? 32'(32'h11 * (i + 1)) : (32'h0100_0000 + 32'(i)));
        end
        write_mem(255, 32'hCAFE_00FF);
        sb.delete();
        n_pops = 0;
        push_seq(32'h0, 16);
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("start_valid_c0", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check("start_valid_c1", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check("start_valid_c2", 32'(bus.o_valid), 32'd1);
        check("start_pc_c2",    bus.o_IF_pc,      32'd0);
        tick();
        wait_pops(8, "stream");

        // Back-pressure: queue saturates at DEPTH, nothing lost
        do_reset();
        maxc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int'(bus.o_count) > maxc) maxc = int'(bus.o_count);
        end
        check("sat_count", 32'(bus.o_count), 32'd4);
        check("sat_max",   32'(maxc),        32'd4);
        check("sat_pc",    bus.o_IF_pc,      32'd0);
        check("sat_nopop", 32'(n_pops),      32'd0);
        push_seq(32'h0, 16);
        bus.i_ready = 1'b1;
        wait_pops(5, "release");

        // Branch with 3 queued entries and a read in flight
        do_reset();
        cyc = 0;
        while (bus.o_count != 3'd3 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("pre_branch_count", 32'(bus.o_count), 32'd3);
        bus.i_branch      = 1'b1;
        bus.i_branch_addr = 32'h0000_0040;
        bus.i_ready       = 1'b1;
        sb.delete();
        push_seq(32'h40, 16);
        n_pops = 0;
        tick();
        bus.i_branch = 1'b0;
        @(negedge clk);
        check("br_count_n1", 32'(bus.o_count), 32'd0);
        check("br_valid_n1", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check("br_valid_n2", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        check("br_valid_n3", 32'(bus.o_valid), 32'd1);
        check("br_pc_n3",    bus.o_IF_pc,      32'h40);
        tick();
        wait_pops(4, "branch");

        // Step freeze mid-stream
        bus.i_step = 1'b0;
        p0 = n_pops;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("frz_valid", 32'(bus.o_valid), 32'd1);
            check("frz_count", 32'(bus.o_count), 32'd1);
            check("frz_pc",    bus.o_IF_pc,      sb[0].pc);
        end
        tick();
        check("frz_nopop", 32'(n_pops), 32'(p0));
        bus.i_step = 1'b1;
        wait_pops(p0 + 4, "resume");

        // Address wrap at the top of memory
        bus.i_branch      = 1'b1;
        bus.i_branch_addr = 32'h0000_03FC;
        sb.delete();
        push_seq(32'h3FC, 3);
        n_pops = 0;
        tick();
        bus.i_branch = 1'b0;
        wait_pops(3, "wrap");
        bus.i_ready = 1'b0;
        tick();

`ifdef IF_HALT_DETECT_EN
        // Halt word stops fetching after it is delivered
        do_reset();
        write_mem(2, 32'hFFFF_FFFF);
        push_seq(32'h0, 3);
        bus.i_ready = 1'b1;
        wait_pops(3, "halt");
        for (int i = 0; i < 10; i++) tick();
        check("halt_flag",  32'(bus.o_halt),  32'd1);
        check("halt_valid", 32'(bus.o_valid), 32'd0);
        check("halt_count", 32'(bus.o_count), 32'd0);
        check("halt_pops",  32'(n_pops),      32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
